// File: rtl/k007232_voice_seq.sv
// ============================================================================
// k007232_voice_seq : round-robin two-voice register write sequencer for k007232
// Rev 1.0
// ============================================================================
`default_nettype none

module k007232_voice_seq #(
  parameter int STROBE_CYC = 2
) (
  input  logic        CLK,
  input  logic        NRES,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [16:0] START_A,
  input  logic [16:0] START_B,
  input  logic [11:0] PITCH_A,
  input  logic [11:0] PITCH_B,
  input  logic [1:0]  MODE_A,
  input  logic [1:0]  MODE_B,
  input  logic        LOOP_A,
  input  logic        LOOP_B,
  output logic        ACK_A,
  output logic        ACK_B,
  output logic        BUSY,
  output logic [3:0]  AB,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  output logic        DACS
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        voice_q, voice_d;   // 0 = A, 1 = B
  logic        last_q, last_d;     // last served voice
  logic        lpa_q, lpa_d, lpb_q, lpb_d;
  logic [16:0] start_q, start_d;
  logic [11:0] pitch_q, pitch_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  ab_q, ab_d;
  logic [7:0]  db_q, db_d;
  logic        oe_q, oe_d, dacs_q, dacs_d, busy_q, busy_d;
  logic        acka_q, acka_d, ackb_q, ackb_d;
  logic [3:0]  reg_n;
  logic [7:0]  wdata;
  logic        grant_a;

  assign grant_a = REQ_A && (!REQ_B || last_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    voice_d = voice_q;
    last_d  = last_q;
    lpa_d   = lpa_q;
    lpb_d   = lpb_q;
    start_d = start_q;
    pitch_d = pitch_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_A || REQ_B) begin
          state_d = S_SETUP;
          idx_d   = 3'd0;
          voice_d = !grant_a;
          if (grant_a) begin
            start_d = START_A;
            pitch_d = PITCH_A;
            mode_d  = MODE_A;
            lpa_d   = LOOP_A;
          end else begin
            start_d = START_B;
            pitch_d = PITCH_B;
            mode_d  = MODE_B;
            lpb_d   = LOOP_B;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 4'd0;
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) state_d = S_HOLD;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      S_HOLD: begin
        if (idx_q == 3'd6) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
          idx_d   = idx_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = voice_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Write list entry for the upcoming write, built from the next-cycle command so
    // the first write is correct on the grant edge itself.
    reg_n = 4'd0;
    wdata = 8'h00;
    case (idx_d)
      3'd0: begin reg_n = voice_d ? 4'd6  : 4'd0; wdata = pitch_d[7:0]; end
      3'd1: begin reg_n = voice_d ? 4'd7  : 4'd1; wdata = {2'b00, mode_d, pitch_d[11:8]}; end
      3'd2: begin reg_n = voice_d ? 4'd8  : 4'd2; wdata = start_d[7:0]; end
      3'd3: begin reg_n = voice_d ? 4'd9  : 4'd3; wdata = start_d[15:8]; end
      3'd4: begin reg_n = voice_d ? 4'd10 : 4'd4; wdata = {7'b0, start_d[16]}; end
      3'd5: begin reg_n = 4'd13;                  wdata = {6'b0, lpb_d, lpa_d}; end
      default: begin reg_n = voice_d ? 4'd11 : 4'd5; wdata = 8'h00; end
    endcase

    ab_d = ab_q;
    db_d = db_q;
    if (state_d == S_SETUP) begin
      ab_d = reg_n ^ 4'h1;   // chip inverts AB[0] internally
      db_d = wdata;
    end
    oe_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    dacs_d = (state_d != S_STROBE);
    busy_d = (state_d != S_IDLE);
    acka_d = (state_d == S_DONE) && !voice_d;
    ackb_d = (state_d == S_DONE) && voice_d;
  end

  always_ff @(posedge CLK) begin
    if (!NRES) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      voice_q <= 1'b0;
      last_q  <= 1'b1;
      lpa_q   <= 1'b0;
      lpb_q   <= 1'b0;
      start_q <= 17'd0;
      pitch_q <= 12'd0;
      mode_q  <= 2'd0;
      ab_q    <= 4'd0;
      db_q    <= 8'h00;
      oe_q    <= 1'b0;
      dacs_q  <= 1'b1;
      busy_q  <= 1'b0;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      voice_q <= voice_d;
      last_q  <= last_d;
      lpa_q   <= lpa_d;
      lpb_q   <= lpb_d;
      start_q <= start_d;
      pitch_q <= pitch_d;
      mode_q  <= mode_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
      oe_q    <= oe_d;
      dacs_q  <= dacs_d;
      busy_q  <= busy_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
    end
  end

  assign ACK_A  = acka_q;
  assign ACK_B  = ackb_q;
  assign BUSY   = busy_q;
  assign AB     = ab_q;
  assign DB_OUT = db_q;
  assign DB_OE  = oe_q;
  assign DACS   = dacs_q;

endmodule

`default_nettype wire
